// File: rtl/snake_move_ctrl.sv
// Snake movement controller: latches direction, steps the head once per tick, and
// drives push/pop/clear strobes for the downstream body stack.
module snake_move_ctrl #(
  parameter int unsigned GRID_W   = 40,
  parameter int unsigned GRID_H   = 30,
  parameter int unsigned INIT_LEN = 3,
  parameter int unsigned MAX_LEN  = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       tick,
  input  logic [3:0] btn,
  input  logic       grow,
  output logic [5:0] head_x,
  output logic [4:0] head_y,
  output logic [2:0] dir_code,
  output logic       push,
  output logic       pop,
  output logic       stack_clr,
  output logic [7:0] length,
  output logic       running,
  output logic       game_over
);

  typedef enum logic [1:0] {StIdle, StRun, StOver} state_e;

  localparam logic [2:0] DirUp    = 3'd0;
  localparam logic [2:0] DirDown  = 3'd1;
  localparam logic [2:0] DirLeft  = 3'd2;
  localparam logic [2:0] DirRight = 3'd3;

  localparam logic [5:0] CenterX = 6'(GRID_W / 2);
  localparam logic [4:0] CenterY = 5'(GRID_H / 2);
  localparam logic [5:0] MaxX    = 6'(GRID_W - 1);
  localparam logic [4:0] MaxY    = 5'(GRID_H - 1);
  localparam logic [7:0] InitLen = 8'(INIT_LEN);
  localparam logic [7:0] MaxLen  = 8'(MAX_LEN);

  state_e     state_q, state_d;
  logic [5:0] head_x_q, head_x_d;
  logic [4:0] head_y_q, head_y_d;
  logic [2:0] dir_q, dir_d;
  logic [2:0] pend_q, pend_d;
  logic [7:0] len_q, len_d;
  logic       grow_pend_q, grow_pend_d;
  logic       push_q, push_d;
  logic       pop_q, pop_d;
  logic       pop_sched_q, pop_sched_d;
  logic       mv2_q, mv2_d;
  logic       clr_q, clr_d;

  logic       busy;
  logic [2:0] btn_dir;
  logic       collide;
  logic       growing;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      head_x_q    <= CenterX;
      head_y_q    <= CenterY;
      dir_q       <= DirRight;
      pend_q      <= DirRight;
      len_q       <= InitLen;
      grow_pend_q <= 1'b0;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      pop_sched_q <= 1'b0;
      mv2_q       <= 1'b0;
      clr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_x_q    <= head_x_d;
      head_y_q    <= head_y_d;
      dir_q       <= dir_d;
      pend_q      <= pend_d;
      len_q       <= len_d;
      grow_pend_q <= grow_pend_d;
      push_q      <= push_d;
      pop_q       <= pop_d;
      pop_sched_q <= pop_sched_d;
      mv2_q       <= mv2_d;
      clr_q       <= clr_d;
    end
  end

  // Ticks are dropped for the two cycles following an accepted move.
  assign busy = push_q | mv2_q;

  always_comb begin
    btn_dir = DirRight;
    if (btn[3])      btn_dir = DirUp;
    else if (btn[2]) btn_dir = DirDown;
    else if (btn[1]) btn_dir = DirLeft;
  end

  always_comb begin
    unique case (pend_q)
      DirUp:   collide = (head_y_q == 5'd0);
      DirDown: collide = (head_y_q == MaxY);
      DirLeft: collide = (head_x_q == 6'd0);
      default: collide = (head_x_q == MaxX);
    endcase
  end

  always_comb begin
    state_d     = state_q;
    head_x_d    = head_x_q;
    head_y_d    = head_y_q;
    dir_d       = dir_q;
    pend_d      = pend_q;
    len_d       = len_q;
    grow_pend_d = grow_pend_q;
    push_d      = 1'b0;
    pop_d       = 1'b0;
    pop_sched_d = pop_sched_q;
    mv2_d       = 1'b0;
    clr_d       = 1'b0;
    growing     = grow_pend_q | grow;
    unique case (state_q)
      StRun: begin
        // Reversal check is against the committed direction, not the pending one.
        if ((btn != 4'd0) && (btn_dir != (dir_q ^ 3'd1))) pend_d = btn_dir;
        if (grow) grow_pend_d = 1'b1;
        mv2_d = push_q;
        pop_d = push_q & pop_sched_q;
        if (tick && !busy) begin
          if (collide) begin
            state_d = StOver;
          end else begin
            unique case (pend_q)
              DirUp:   head_y_d = head_y_q - 5'd1;
              DirDown: head_y_d = head_y_q + 5'd1;
              DirLeft: head_x_d = head_x_q - 6'd1;
              default: head_x_d = head_x_q + 6'd1;
            endcase
            dir_d       = pend_q;
            push_d      = 1'b1;
            grow_pend_d = 1'b0;
            if (growing && (len_q != MaxLen)) begin
              len_d       = len_q + 8'd1;
              pop_sched_d = 1'b0;
            end else begin
              pop_sched_d = 1'b1;
            end
          end
        end
      end
      default: begin
        if (start) begin
          state_d     = StRun;
          head_x_d    = CenterX;
          head_y_d    = CenterY;
          dir_d       = DirRight;
          pend_d      = DirRight;
          len_d       = InitLen;
          grow_pend_d = 1'b0;
          pop_sched_d = 1'b0;
          clr_d       = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    head_x    = head_x_q;
    head_y    = head_y_q;
    dir_code  = dir_q;
    push      = push_q;
    pop       = pop_q;
    stack_clr = clr_q;
    length    = len_q;
    running   = (state_q == StRun);
    game_over = (state_q == StOver);
  end

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Directed bench for snake_move_ctrl: movement, direction filtering, growth, walls,
// restart and reset-during-move, each checked against hand-computed values.
module tb_snake_move_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, tick, grow;
  logic [3:0] btn;
  logic [5:0] head_x;
  logic [4:0] head_y;
  logic [2:0] dir_code;
  logic       push, pop, stack_clr, running, game_over;
  logic [7:0] length;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  snake_move_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .tick      (tick),
    .btn       (btn),
    .grow      (grow),
    .head_x    (head_x),
    .head_y    (head_y),
    .dir_code  (dir_code),
    .push      (push),
    .pop       (pop),
    .stack_clr (stack_clr),
    .length    (length),
    .running   (running),
    .game_over (game_over)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse tick for one cycle; returns 1 ns after the edge that samples it (cycle T+1).
  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; tick = 1'b0; grow = 1'b0; btn = 4'd0;
    step(); step();
    reset = 1'b0;
    check("rst_x", head_x, 20);
    check("rst_y", head_y, 15);
    check("rst_dir", dir_code, 3);
    check("rst_len", length, 3);
    check("rst_strobes", {push, pop, stack_clr, running, game_over}, 0);

    do_tick();
    step();
    check("idle_tick_x", head_x, 20);
    check("idle_tick_push", push, 0);

    start = 1'b1; tick = 1'b1;
    step();
    start = 1'b0; tick = 1'b0;
    check("start_clr", stack_clr, 1);
    check("start_run", running, 1);
    check("start_tick_ignored", push, 0);
    step();
    check("clr_one_cycle", stack_clr, 0);

    for (int i = 0; i < 3; i++) begin
      do_tick();
      check("mv_x", head_x, 21 + i);
      check("mv_push", {push, pop}, 2'b10);
      check("mv_dir", dir_code, 3);
      step();
      check("mv_pop", {push, pop}, 2'b01);
      step();
    end
    check("mv_len", length, 3);

    btn = 4'b0010; step(); btn = 4'd0;
    do_tick();
    check("rev_x", head_x, 24);
    check("rev_dir", dir_code, 3);
    step(); step();
    btn = 4'b1010; step(); btn = 4'd0;
    do_tick();
    check("up_dir", dir_code, 0);
    check("up_y", head_y, 14);
    check("up_x", head_x, 24);
    step(); step();
    btn = 4'b0001; step(); btn = 4'd0;
    do_tick();
    check("right_x", head_x, 25);
    step(); step();

    grow = 1'b1; step(); grow = 1'b0;
    do_tick();
    check("grow_push", push, 1);
    check("grow_len", length, 4);
    step();
    check("grow_nopop", pop, 0);
    step();
    do_tick();
    check("after_grow_x", head_x, 27);
    step();
    check("after_grow_pop", pop, 1);
    check("after_grow_len", length, 4);
    step();

    // Grow coincident with the tick applies to that move.
    grow = 1'b1;
    do_tick();
    grow = 1'b0;
    check("grow_same_len", length, 5);
    step();
    check("grow_same_nopop", pop, 0);
    step();

    for (int i = 0; i < 11; i++) begin
      do_tick(); step(); step();
    end
    check("wall_x", head_x, 39);
    do_tick();
    check("wall_over", game_over, 1);
    check("wall_run", running, 0);
    check("wall_push", push, 0);
    check("wall_x_hold", head_x, 39);
    check("wall_y_hold", head_y, 14);
    step();
    check("wall_pop", pop, 0);
    do_tick(); step();
    check("over_tick_x", head_x, 39);

    start = 1'b1; step(); start = 1'b0;
    check("restart_clr", stack_clr, 1);
    check("restart_xy", {head_x, head_y}, {6'd20, 5'd15});
    check("restart_len", length, 3);
    check("restart_run", {running, game_over}, 2'b10);
    step();
    check("restart_clr_off", stack_clr, 0);

    tick = 1'b1; step(); step(); tick = 1'b0;
    check("dbl_x", head_x, 21);
    check("dbl_pop", {push, pop}, 2'b01);
    step();
    check("dbl_nopush", {push, pop}, 2'b00);
    check("dbl_x_hold", head_x, 21);
    step();

    do_tick();
    check("pre_rst_push", push, 1);
    reset = 1'b1; step(); reset = 1'b0;
    check("rst_mid_pop", pop, 0);
    check("rst_mid_xy", {head_x, head_y}, {6'd20, 5'd15});
    check("rst_mid_state", {running, game_over, stack_clr}, 0);
    check("rst_mid_len_dir", {length, dir_code}, {8'd3, 3'd3});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
